// File: rtl/rv32i_types_pkg.sv
// Shared RV32I front-end types: machine word, canonical NOP and fetch FSM states.
package rv32i_types_pkg;

  typedef logic [31:0] word_t;

  localparam word_t RV32I_NOP = 32'h0000_0013;

  typedef enum logic {
    FETCH   = 1'b0,
    DISCARD = 1'b1
  } fetch_state_t;

  // Sequential PC step; wraps silently at the top of the address space.
  function automatic word_t pcPlus4(input word_t pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry holding register for a fetch that completed while execute was stalled.
// Entry layout is {valid, instr, pc}; pc4 is recomputed by the consumer on pop.
module fetch_skid_buffer
  import rv32i_types_pkg::*;
(
  input  logic  clk_i,
  input  logic  rst_i,
  input  logic  push_i,
  input  logic  pop_i,
  input  logic  clear_i,
  input  word_t instr_i,
  input  word_t pc_i,
  output logic  valid_o,
  output word_t instr_o,
  output word_t pc_o
);

  logic [64:0] entry_q, entry_d;

  always_comb begin
    entry_d = entry_q;
    if (clear_i) begin
      entry_d = '0;
    end else if (push_i) begin
      entry_d = {1'b1, instr_i, pc_i};
    end else if (pop_i) begin
      entry_d[64] = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      entry_q <= '0;
    end else begin
      entry_q <= entry_d;
    end
  end

  assign valid_o = entry_q[64];
  assign instr_o = entry_q[63:32];
  assign pc_o    = entry_q[31:0];

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: owns the PC, issues instruction-bus reads and fills the fetch/execute latch.
// A redirect during an outstanding read parks in DISCARD until the stale response returns.
module fetch_stage
  import rv32i_types_pkg::*;
#(
  parameter word_t RESET_PC = 32'h0000_0200
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        update_pc,
  input  logic [31:0] update_addr,
  input  logic        flush,
  input  logic        stall,
  output logic        iren,
  output logic [31:0] iaddr,
  input  logic        ibusy,
  input  logic [31:0] irdata,
  output logic        fe_valid,
  output logic [31:0] fe_instr,
  output logic [31:0] fe_pc,
  output logic [31:0] fe_pc4,
  output logic        fe_fault,
  output logic        imem_busy
);

  fetch_state_t state_q, state_d;
  word_t        pc_q, pc_d;
  word_t        redirectPc_q, redirectPc_d;
  logic         faultDone_q, faultDone_d;
  logic         feValid_q, feValid_d;
  word_t        feInstr_q, feInstr_d;
  word_t        fePc_q, fePc_d;
  word_t        fePc4_q, fePc4_d;
  logic         feFault_q, feFault_d;

  logic  skidPush, skidPop, skidClear, skidValid;
  word_t skidInstr, skidPc;
  logic  pcAligned, readDone, fetchDone, faultPending;

  // No new read may start while the skid holds an entry, so a push never meets a full buffer.
  assign pcAligned    = (pc_q[1:0] == 2'b00);
  assign iren         = (state_q == DISCARD) || (!skidValid && pcAligned);
  assign iaddr        = pc_q;
  assign imem_busy    = iren & ibusy;
  assign readDone     = iren & ~ibusy;
  assign fetchDone    = readDone && (state_q == FETCH) && !update_pc;
  assign faultPending = (state_q == FETCH) && !pcAligned && !faultDone_q && !update_pc;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    redirectPc_d = redirectPc_q;
    faultDone_d  = faultDone_q;
    feValid_d    = feValid_q;
    feInstr_d    = feInstr_q;
    fePc_d       = fePc_q;
    fePc4_d      = fePc4_q;
    feFault_d    = feFault_q;
    skidPush     = 1'b0;
    skidPop      = 1'b0;
    skidClear    = 1'b0;

    case (state_q)
      FETCH: begin
        if (update_pc) begin
          if (iren && ibusy) begin
            state_d      = DISCARD;
            redirectPc_d = update_addr;
          end else begin
            pc_d        = update_addr;
            faultDone_d = 1'b0;
          end
        end else if (readDone) begin
          pc_d = pcPlus4(pc_q);
        end
      end
      DISCARD: begin
        if (update_pc) begin
          redirectPc_d = update_addr;
        end
        if (readDone) begin
          state_d     = FETCH;
          pc_d        = update_pc ? update_addr : redirectPc_q;
          faultDone_d = 1'b0;
        end
      end
      default: state_d = FETCH;
    endcase

    // Latch priority: flush, then stall, then draining the skid, then new work.
    if (flush) begin
      feValid_d = 1'b0;
      skidClear = 1'b1;
    end else if (stall) begin
      skidPush = fetchDone;
    end else if (skidValid) begin
      skidPop   = 1'b1;
      feValid_d = 1'b1;
      feInstr_d = skidInstr;
      fePc_d    = skidPc;
      fePc4_d   = pcPlus4(skidPc);
      feFault_d = 1'b0;
    end else if (fetchDone) begin
      feValid_d = 1'b1;
      feInstr_d = irdata;
      fePc_d    = pc_q;
      fePc4_d   = pcPlus4(pc_q);
      feFault_d = 1'b0;
    end else if (faultPending) begin
      feValid_d   = 1'b1;
      feInstr_d   = RV32I_NOP;
      fePc_d      = pc_q;
      fePc4_d     = pcPlus4(pc_q);
      feFault_d   = 1'b1;
      faultDone_d = 1'b1;
    end else begin
      feValid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      redirectPc_q <= RESET_PC;
      faultDone_q  <= 1'b0;
      feValid_q    <= 1'b0;
      feInstr_q    <= RV32I_NOP;
      fePc_q       <= '0;
      fePc4_q      <= '0;
      feFault_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      redirectPc_q <= redirectPc_d;
      faultDone_q  <= faultDone_d;
      feValid_q    <= feValid_d;
      feInstr_q    <= feInstr_d;
      fePc_q       <= fePc_d;
      fePc4_q      <= fePc4_d;
      feFault_q    <= feFault_d;
    end
  end

  fetch_skid_buffer uSkid (
    .clk_i   (CLK),
    .rst_i   (RST),
    .push_i  (skidPush),
    .pop_i   (skidPop),
    .clear_i (skidClear),
    .instr_i (irdata),
    .pc_i    (pc_q),
    .valid_o (skidValid),
    .instr_o (skidInstr),
    .pc_o    (skidPc)
  );

  assign fe_valid = feValid_q;
  assign fe_instr = feInstr_q;
  assign fe_pc    = fePc_q;
  assign fe_pc4   = fePc4_q;
  assign fe_fault = feFault_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: cycle tables for the corner cases, then a randomized run checked
// against a program-order model of which PCs execute must receive.
module tb_fetch_stage;

  logic        CLK = 1'b0;
  logic        RST;
  logic        update_pc, flush, stall, ibusy;
  logic [31:0] update_addr;
  logic        iren, fe_valid, fe_fault, imem_busy;
  logic [31:0] iaddr, irdata, fe_instr, fe_pc, fe_pc4;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  // Instruction memory contents: a scrambled function of the address.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  assign irdata = memWord(iaddr);

  fetch_stage #(.RESET_PC(32'h0000_0200)) dut (
    .CLK(CLK), .RST(RST), .update_pc(update_pc), .update_addr(update_addr),
    .flush(flush), .stall(stall), .iren(iren), .iaddr(iaddr), .ibusy(ibusy),
    .irdata(irdata), .fe_valid(fe_valid), .fe_instr(fe_instr), .fe_pc(fe_pc),
    .fe_pc4(fe_pc4), .fe_fault(fe_fault), .imem_busy(imem_busy)
  );

  typedef struct {
    int          seg;
    logic        rst, stall, flush, upd;
    logic [31:0] addr;
    logic        busy;
    logic        expIren;
    logic [31:0] expIaddr;
    logic        expValid;
    logic [31:0] expPc;
    logic        expFault;
  } vec_t;

  vec_t vecs[$];

  function automatic void addRow(input int seg, input logic rst, input logic stl,
                                 input logic fl, input logic upd, input logic [31:0] addr,
                                 input logic busy, input logic eIren, input logic [31:0] eAddr,
                                 input logic eValid, input logic [31:0] ePc, input logic eFault);
    vec_t v;
    v.seg = seg; v.rst = rst; v.stall = stl; v.flush = fl; v.upd = upd; v.addr = addr;
    v.busy = busy; v.expIren = eIren; v.expIaddr = eAddr; v.expValid = eValid;
    v.expPc = ePc; v.expFault = eFault;
    vecs.push_back(v);
  endfunction

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Holds reset for two edges, checks the reset image, then releases at the start of a cycle.
  task automatic doReset();
    RST = 1'b1; update_pc = 1'b0; update_addr = '0; flush = 1'b0; stall = 1'b0; ibusy = 1'b0;
    @(posedge CLK); @(posedge CLK); #1;
    checkVal("reset iren", iren, 1);
    checkVal("reset iaddr", iaddr, 32'h200);
    checkVal("reset fe_valid", fe_valid, 0);
    checkVal("reset fe_instr", fe_instr, 32'h13);
    checkVal("reset fe_pc", fe_pc, 0);
    checkVal("reset fe_pc4", fe_pc4, 0);
    checkVal("reset fe_fault", fe_fault, 0);
    RST = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v);
    RST = v.rst; stall = v.stall; flush = v.flush; update_pc = v.upd;
    update_addr = v.addr; ibusy = v.busy;
  endtask

  task automatic checkOutput(input int row, input vec_t v);
    logic [31:0] expInstr;
    expInstr = v.expFault ? 32'h0000_0013 : memWord(v.expPc);
    checkVal($sformatf("row%0d iren", row), iren, v.expIren);
    checkVal($sformatf("row%0d iaddr", row), iaddr, v.expIaddr);
    checkVal($sformatf("row%0d imem_busy", row), imem_busy, v.expIren & v.busy);
    checkVal($sformatf("row%0d fe_valid", row), fe_valid, v.expValid);
    if (v.expValid) begin
      checkVal($sformatf("row%0d fe_pc", row), fe_pc, v.expPc);
      checkVal($sformatf("row%0d fe_pc4", row), fe_pc4, v.expPc + 32'd4);
      checkVal($sformatf("row%0d fe_instr", row), fe_instr, expInstr);
      checkVal($sformatf("row%0d fe_fault", row), fe_fault, v.expFault);
    end
  endtask

  // Randomized-phase bus responder state.
  logic reqActive, prevIren, prevCompleted, lastBusyReq;
  int   waitCnt;
  logic [31:0] lastAddr;

  task automatic busStep();
    if (prevCompleted || !prevIren) reqActive = 1'b0;
    else if (waitCnt > 0) waitCnt--;
    if (iren && !reqActive) begin
      reqActive = 1'b1;
      waitCnt   = $urandom_range(0, 3);
    end
    ibusy = reqActive && (waitCnt != 0);
  endtask

  initial begin
    int prevSeg;
    int consumed;
    logic [31:0] expectedPc, target;
    logic doRedirect;

    // seg, rst, stall, flush, upd, addr, busy | iren, iaddr, valid, pc, fault
    // Redirect while 0x204 is busy for three cycles.
    addRow(0,0,0,0,0,32'h0,  0, 1,32'h200,0,32'h0,  0);
    addRow(0,0,0,0,1,32'h400,1, 1,32'h204,1,32'h200,0);
    addRow(0,0,0,0,0,32'h0,  1, 1,32'h204,0,32'h0,  0);
    addRow(0,0,0,0,0,32'h0,  1, 1,32'h204,0,32'h0,  0);
    addRow(0,0,0,0,0,32'h0,  0, 1,32'h204,0,32'h0,  0);
    addRow(0,0,0,0,0,32'h0,  0, 1,32'h400,0,32'h0,  0);
    addRow(0,0,0,0,0,32'h0,  0, 1,32'h404,1,32'h400,0);
    addRow(0,0,0,0,0,32'h0,  0, 1,32'h408,1,32'h404,0);
    // Stall for two cycles while 0x208 completes.
    addRow(1,0,0,0,0,32'h0,  0, 1,32'h200,0,32'h0,  0);
    addRow(1,0,0,0,0,32'h0,  0, 1,32'h204,1,32'h200,0);
    addRow(1,0,1,0,0,32'h0,  0, 1,32'h208,1,32'h204,0);
    addRow(1,0,1,0,0,32'h0,  0, 0,32'h20C,1,32'h204,0);
    addRow(1,0,0,0,0,32'h0,  0, 0,32'h20C,1,32'h204,0);
    addRow(1,0,0,0,0,32'h0,  0, 1,32'h20C,1,32'h208,0);
    addRow(1,0,0,0,0,32'h0,  0, 1,32'h210,1,32'h20C,0);
    // Flush with the skid full: 0x208 is never presented.
    addRow(2,0,0,0,0,32'h0,  0, 1,32'h200,0,32'h0,  0);
    addRow(2,0,0,0,0,32'h0,  0, 1,32'h204,1,32'h200,0);
    addRow(2,0,1,0,0,32'h0,  0, 1,32'h208,1,32'h204,0);
    addRow(2,0,0,1,0,32'h0,  0, 0,32'h20C,1,32'h204,0);
    addRow(2,0,0,0,0,32'h0,  0, 1,32'h20C,0,32'h0,  0);
    addRow(2,0,0,0,0,32'h0,  0, 1,32'h210,1,32'h20C,0);
    // Misaligned target: one fault entry, no bus read, then recovery.
    addRow(3,0,0,0,1,32'h402,0, 1,32'h200,0,32'h0,  0);
    addRow(3,0,0,0,0,32'h0,  0, 0,32'h402,0,32'h0,  0);
    addRow(3,0,0,0,0,32'h0,  0, 0,32'h402,1,32'h402,1);
    addRow(3,0,0,0,0,32'h0,  0, 0,32'h402,0,32'h0,  0);
    addRow(3,0,0,0,1,32'h500,0, 0,32'h402,0,32'h0,  0);
    addRow(3,0,0,0,0,32'h0,  0, 1,32'h500,0,32'h0,  0);
    addRow(3,0,0,0,0,32'h0,  0, 1,32'h504,1,32'h500,0);
    // PC wrap at the top of memory.
    addRow(4,0,0,0,1,32'hFFFF_FFFC,0, 1,32'h200,0,32'h0,0);
    addRow(4,0,0,0,0,32'h0,  0, 1,32'hFFFF_FFFC,0,32'h0,0);
    addRow(4,0,0,0,0,32'h0,  0, 1,32'h0,1,32'hFFFF_FFFC,0);
    addRow(4,0,0,0,0,32'h0,  0, 1,32'h4,1,32'h0,0);
    // Reset mid-read at 0x300.
    addRow(5,0,0,0,1,32'h300,0, 1,32'h200,0,32'h0,  0);
    addRow(5,0,0,0,0,32'h0,  1, 1,32'h300,0,32'h0,  0);
    addRow(5,1,0,0,0,32'h0,  1, 1,32'h300,0,32'h0,  0);
    addRow(5,0,0,0,0,32'h0,  0, 1,32'h200,0,32'h0,  0);
    addRow(5,0,0,0,0,32'h0,  0, 1,32'h204,1,32'h200,0);
    // Second redirect while discarding overrides the first.
    addRow(6,0,0,0,1,32'h600,1, 1,32'h200,0,32'h0,  0);
    addRow(6,0,0,0,1,32'h700,1, 1,32'h200,0,32'h0,  0);
    addRow(6,0,0,0,0,32'h0,  0, 1,32'h200,0,32'h0,  0);
    addRow(6,0,0,0,0,32'h0,  0, 1,32'h700,0,32'h0,  0);
    addRow(6,0,0,0,0,32'h0,  0, 1,32'h704,1,32'h700,0);

    prevSeg = -1;
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].seg != prevSeg) begin
        doReset();
        prevSeg = vecs[i].seg;
      end
      applyStimulus(vecs[i]);
      @(negedge CLK);
      checkOutput(i, vecs[i]);
      @(posedge CLK); #1;
    end

    // Randomized run: execute must see every PC in program order exactly once,
    // restarting at the target after each flush+redirect.
    doReset();
    reqActive = 1'b0; prevIren = 1'b0; prevCompleted = 1'b0; lastBusyReq = 1'b0;
    waitCnt = 0; lastAddr = '0;
    expectedPc = 32'h200;
    consumed = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      stall      = ($urandom_range(0, 9) < 3);
      doRedirect = ($urandom_range(0, 31) == 0);
      target     = 32'h1000 + {20'd0, 10'($urandom_range(0, 1023)), 2'b00};
      flush       = doRedirect;
      update_pc   = doRedirect;
      update_addr = target;
      busStep();
      @(negedge CLK);
      if (lastBusyReq) begin
        checkVal("bus iren held", iren, 1);
        checkVal("bus iaddr stable", iaddr, lastAddr);
      end
      if (fe_valid && !stall && !flush) begin
        checkVal("rand fe_pc", fe_pc, expectedPc);
        checkVal("rand fe_pc4", fe_pc4, expectedPc + 32'd4);
        checkVal("rand fe_instr", fe_instr, memWord(expectedPc));
        checkVal("rand fe_fault", fe_fault, 0);
        expectedPc = fe_pc + 32'd4;
        consumed++;
      end
      if (doRedirect) expectedPc = target;
      lastBusyReq   = iren && ibusy;
      lastAddr      = iaddr;
      prevIren      = iren;
      prevCompleted = iren && !ibusy;
      @(posedge CLK); #1;
    end
    checkVal("rand progress", (consumed >= 300) ? 32'd1 : 32'd0, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
